// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage: data width, the NOP
// encoding and the fetch controller state codes.
package instr_fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] FETCH_NOP  = 32'h0000_0013;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_FULL  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return |lowBits;
    endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {pc, instr} holding slot used while decode is halted.
module instr_fetch_skid_buf
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    // Flush beats everything; a load in the same cycle as an unload refills the slot.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: sequential PC generation over a single-outstanding req/ack
// instruction port, a one-word skid slot for decode halts, and redirect flushing.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid,
    output logic            fetch_misalign
);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] drainAddr_q, drainAddr_d;
    logic [XLEN-1:0] outPc_q, outPc_d;
    logic [XLEN-1:0] outInstr_q, outInstr_d;
    logic            outValid_q, outValid_d;
    logic            misalign_q, misalign_d;

    logic            skidLoad, skidUnload, skidFlush, skidFull;
    logic [XLEN-1:0] skidPc, skidInstr;
    logic            keepWord, slotFullNext;
    logic [XLEN-1:0] redirectTarget;
    logic            redirectMisaligned;

    // DRAIN keeps presenting the abandoned address so the request is never withdrawn.
    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr = (state_q == ST_DRAIN) ? drainAddr_q : fetchPc_q;
    assign keepWord  = imem_ack && (state_q == ST_REQ);

    assign redirectTarget     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirectMisaligned = isMisaligned(redirect_pc[1:0]);

    always_comb begin
        state_d      = state_q;
        fetchPc_d    = fetchPc_q;
        drainAddr_d  = drainAddr_q;
        misalign_d   = misalign_q;
        outPc_d      = outPc_q;
        outInstr_d   = outInstr_q;
        outValid_d   = outValid_q;
        skidLoad     = 1'b0;
        skidUnload   = 1'b0;
        skidFlush    = 1'b0;
        slotFullNext = 1'b0;

        if (redirect_valid) begin
            fetchPc_d  = redirectTarget;
            misalign_d = redirectMisaligned;
            skidFlush  = 1'b1;
            outInstr_d = NOP_INSTR;
            outValid_d = 1'b0;
            if (imem_req && !imem_ack) begin
                state_d = ST_DRAIN;
                if (state_q == ST_REQ) begin
                    drainAddr_d = fetchPc_q;
                end
            end else begin
                state_d = redirectMisaligned ? ST_STOP : ST_REQ;
            end
        end else begin
            // Older word in the slot always leaves first; a same-cycle ack refills it.
            if (!halt) begin
                if (skidFull) begin
                    outPc_d    = skidPc;
                    outInstr_d = skidInstr;
                    outValid_d = 1'b1;
                    skidUnload = 1'b1;
                    skidLoad   = keepWord;
                end else if (keepWord) begin
                    outPc_d    = fetchPc_q;
                    outInstr_d = imem_rdata;
                    outValid_d = 1'b1;
                end else begin
                    outInstr_d = NOP_INSTR;
                    outValid_d = 1'b0;
                end
            end else begin
                skidLoad = keepWord;
            end

            slotFullNext = halt ? (skidFull || keepWord) : (skidFull && keepWord);

            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (keepWord) begin
                        fetchPc_d = fetchPc_q + XLEN'(4);
                    end
                    state_d = slotFullNext ? ST_FULL : ST_REQ;
                end
                ST_FULL:  state_d = slotFullNext ? ST_FULL : ST_REQ;
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_d = misalign_q ? ST_STOP : ST_REQ;
                    end
                end
                ST_STOP:  state_d = ST_STOP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetchPc_q   <= RESET_PC;
            drainAddr_q <= '0;
            misalign_q  <= 1'b0;
            outPc_q     <= '0;
            outInstr_q  <= NOP_INSTR;
            outValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetchPc_q   <= fetchPc_d;
            drainAddr_q <= drainAddr_d;
            misalign_q  <= misalign_d;
            outPc_q     <= outPc_d;
            outInstr_q  <= outInstr_d;
            outValid_q  <= outValid_d;
        end
    end

    instr_fetch_skid_buf #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) skidBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skidLoad),
        .unload_i (skidUnload),
        .flush_i  (skidFlush),
        .pc_i     (fetchPc_q),
        .instr_i  (imem_rdata),
        .full_o   (skidFull),
        .pc_o     (skidPc),
        .instr_o  (skidInstr)
    );

    assign pc_out         = outPc_q;
    assign instr_out      = outInstr_q;
    assign instr_valid    = outValid_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// halt/ack/redirect traffic against a queue-based fetch-stream model.
module tb_instr_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address, so every word is traceable.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    // Acking into a full slot while halted must be impossible by construction.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_req && imem_ack && halt && dut.skidBuf.full_o))
                else $error("[TB] ack arrived while halted with a full skid slot");
        end
    end

    // Reference model: next correct-path PC, a FIFO of fetched-but-undelivered
    // words (capacity one), and flags for started / stopped / draining.
    bit          mStarted, mStopped, mDraining;
    logic [31:0] mPc, mDrainAddr, mOutPc, mOutInstr;
    logic        mOutValid;
    logic [63:0] slotQ[$];

    function automatic logic expReq();
        return mStarted && (mDraining || (!mStopped && slotQ.size() == 0));
    endfunction

    function automatic logic [31:0] expAddr();
        return mDraining ? mDrainAddr : mPc;
    endfunction

    function automatic logic [98:0] expVec();
        return {expReq(), expReq() ? expAddr() : 32'h0, mOutPc, mOutInstr, mOutValid, mStopped};
    endfunction

    function automatic logic [98:0] dutVec();
        return {imem_req, imem_req ? imem_addr : 32'h0, pc_out, instr_out, instr_valid, fetch_misalign};
    endfunction

    task automatic modelReset();
        mStarted  = 1'b0;
        mStopped  = 1'b0;
        mDraining = 1'b0;
        mPc       = RESET_PC;
        mDrainAddr = 32'h0;
        mOutPc    = 32'h0;
        mOutInstr = NOP;
        mOutValid = 1'b0;
        slotQ.delete();
    endtask

    task automatic modelAdvance();
        logic        reqNow, ackNow;
        logic [31:0] addrNow;
        logic [63:0] w;
        reqNow  = expReq();
        addrNow = expAddr();
        ackNow  = reqNow && imem_ack;
        if (redirect_valid) begin
            if (reqNow && !imem_ack) begin
                if (!mDraining) mDrainAddr = addrNow;
                mDraining = 1'b1;
            end else begin
                mDraining = 1'b0;
            end
            mStopped  = (redirect_pc[1:0] != 2'b00);
            mPc       = {redirect_pc[31:2], 2'b00};
            mStarted  = 1'b1;
            slotQ.delete();
            mOutInstr = NOP;
            mOutValid = 1'b0;
        end else begin
            mStarted = 1'b1;
            if (ackNow && mDraining) begin
                mDraining = 1'b0;
            end else if (ackNow) begin
                slotQ.push_back({addrNow, memWord(addrNow)});
                mPc = mPc + 32'd4;
            end
            if (!halt) begin
                if (slotQ.size() != 0) begin
                    w = slotQ.pop_front();
                    mOutPc    = w[63:32];
                    mOutInstr = w[31:0];
                    mOutValid = 1'b1;
                end else begin
                    mOutInstr = NOP;
                    mOutValid = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, return at the negedge.
    task automatic applyStimulus(input logic h, input logic rv, input logic [31:0] rpc, input logic a);
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = a;
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, pc_out, instr_out, instr_valid, fetch_misalign} !== {1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got req=%b pc=%h instr=%h v=%b mis=%b exp req=0 pc=0 instr=%h v=0 mis=0",
                     imem_req, pc_out, instr_out, instr_valid, fetch_misalign, NOP);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL seq_model step=%0d got=%h exp=%h", i, dutVec(), expVec());
            end
            if (i == 0) begin
                checks++;
                if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL seq_first_req got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
                             imem_req, imem_addr, instr_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({instr_valid, pc_out, instr_out} !== {1'b1, 32'h0, memWord(32'h0)}) begin
                    errors++;
                    $display("[TB] FAIL seq_first_valid got v=%b pc=%h instr=%h exp v=1 pc=0 instr=%h",
                             instr_valid, pc_out, instr_out, memWord(32'h0));
                end
            end
        end
    endtask

    task automatic test_halt_skid();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({pc_out, instr_valid, imem_req} !== {32'h0C, 1'b1, 1'b0} || dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL halt_frozen step=%0d got pc=%h v=%b req=%b exp pc=0c v=1 req=0 (vec %h vs %h)",
                         i, pc_out, instr_valid, imem_req, dutVec(), expVec());
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_out, instr_valid} !== {32'h10, memWord(32'h10), 1'b1}) begin
            errors++;
            $display("[TB] FAIL halt_release_skid got pc=%h instr=%h v=%b exp pc=10 instr=%h v=1",
                     pc_out, instr_out, instr_valid, memWord(32'h10));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_out, instr_valid} !== {32'h14, memWord(32'h14), 1'b1} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL halt_release_next got pc=%h instr=%h v=%b exp pc=14 instr=%h v=1",
                     pc_out, instr_out, instr_valid, memWord(32'h14));
        end
    endtask

    task automatic test_redirect_drain();
        int budget = 10;
        while (expAddr() != 32'h20 && budget > 0) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            budget--;
        end
        checks++;
        if (budget == 0 || imem_addr !== 32'h20) begin
            errors++;
            $display("[TB] FAIL drain_reach_0x20 got addr=%h exp addr=00000020", imem_addr);
        end
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
        checks++;
        if ({instr_valid, instr_out, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h20}) begin
            errors++;
            $display("[TB] FAIL drain_redirect got v=%b instr=%h req=%b addr=%h exp v=0 instr=%h req=1 addr=20",
                     instr_valid, instr_out, imem_req, imem_addr, NOP);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h200, 1'b0} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL drain_target got req=%b addr=%h v=%b exp req=1 addr=200 v=0",
                     imem_req, imem_addr, instr_valid);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_out, instr_valid} !== {32'h200, memWord(32'h200), 1'b1}) begin
            errors++;
            $display("[TB] FAIL drain_first_target got pc=%h instr=%h v=%b exp pc=200 v=1",
                     pc_out, instr_out, instr_valid);
        end
    endtask

    task automatic test_redirect_full();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (imem_req !== 1'b0 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL full_slot got=%h exp=%h", dutVec(), expVec());
        end
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b1);
        checks++;
        if ({instr_valid, instr_out, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h400}) begin
            errors++;
            $display("[TB] FAIL full_redirect got v=%b instr=%h req=%b addr=%h exp v=0 instr=%h req=1 addr=400",
                     instr_valid, instr_out, imem_req, imem_addr, NOP);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_valid} !== {32'h400, 1'b1} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL full_resume got pc=%h v=%b exp pc=400 v=1", pc_out, instr_valid);
        end
    endtask

    task automatic test_misalign();
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
        checks++;
        if ({fetch_misalign, imem_req, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL misalign_set got mis=%b req=%b v=%b exp mis=1 req=0 v=0",
                     fetch_misalign, imem_req, instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({fetch_misalign, imem_req} !== {1'b1, 1'b0} || dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL misalign_hold step=%0d got mis=%b req=%b exp mis=1 req=0", i, fetch_misalign, imem_req);
            end
        end
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
        checks++;
        if ({fetch_misalign, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            errors++;
            $display("[TB] FAIL misalign_clear got mis=%b req=%b addr=%h exp mis=0 req=1 addr=300",
                     fetch_misalign, imem_req, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_valid} !== {32'h300, 1'b1} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL misalign_resume got pc=%h v=%b exp pc=300 v=1", pc_out, instr_valid);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_req, imem_addr, pc_out} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("[TB] FAIL wrap_addr got req=%b addr=%h pc=%h exp req=1 addr=0 pc=fffffffc",
                     imem_req, imem_addr, pc_out);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_out, instr_valid} !== {32'h0, memWord(32'h0), 1'b1} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL wrap_output got pc=%h instr=%h v=%b exp pc=0 v=1", pc_out, instr_out, instr_valid);
        end
    endtask

    task automatic test_random();
        logic        h, rv, a;
        logic [31:0] tgt;
        for (int i = 0; i < 500; i++) begin
            h  = ($urandom % 4) == 0;
            a  = ($urandom % 3) != 0;
            rv = ($urandom % 20) == 0;
            tgt = $urandom & 32'h0000_0FFC;
            if (($urandom % 8) == 0) tgt = tgt | 32'hFFFF_F000;
            if (($urandom % 5) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            applyStimulus(h, rv, tgt, a);
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL random step=%0d got=%h exp=%h", i, dutVec(), expVec());
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("[TB] FAIL areset_pending got req=%b addr=%h exp req=1 addr=80", imem_req, imem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checks++;
        if ({imem_req, pc_out, instr_out, instr_valid, fetch_misalign} !== {1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL areset_immediate got req=%b pc=%h instr=%h v=%b mis=%b exp req=0 pc=0 instr=%h v=0 mis=0",
                     imem_req, pc_out, instr_out, instr_valid, fetch_misalign, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL areset_restart got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({pc_out, instr_valid} !== {RESET_PC, 1'b1} || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL areset_first_word got pc=%h v=%b exp pc=%h v=1", pc_out, instr_valid, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_halt_skid();
        test_redirect_drain();
        test_redirect_full();
        test_misalign();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
